demux_dispatch_ctrl: RTL and testbench

- Upstream feeder for the parameterised demux (`demux_param`).
- Accepts a stream of (destination, data) requests on a valid/ready handshake and buffers them in a small FIFO.
- Issues one request per cycle as registered `sel`/`data_out`, plus a one-hot lane strobe, so downstream per-lane registers latch only their own word.
- Honours per-destination backpressure and drops out-of-range destinations.

---
 rtl/demux_dispatch_pkg.sv | 22 ++
 rtl/sync_fifo_param.sv | 58 +++++
 rtl/demux_dispatch_ctrl.sv | 115 +++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_dispatch_pkg.sv
// Shared constants and types for the demux dispatch controller.
// Entry layout in the FIFO is {dest, data}, with dest in the MSBs.
package demux_dispatch_pkg;

  localparam int NUM_OUTPUT = 15;
  localparam int SEL_WIDTH  = 4;
  localparam int DATA_WIDTH = 4;
  localparam int DEPTH      = 4;

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int FILL_W  = $clog2(DEPTH + 1);
  localparam int ENTRY_W = SEL_WIDTH + DATA_WIDTH;

  // What the head-of-queue entry does this cycle
  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_STALL,
    ACT_ISSUE,
    ACT_DROP
  } head_act_e;

endpackage

// File: rtl/sync_fifo_param.sv
// Small first-word-fall-through FIFO: head entry is visible combinationally,
// occupancy tracked separately from the wrapping pointers, synchronous flush.
module sync_fifo_param #(
  parameter int DEPTH = demux_dispatch_pkg::DEPTH,
  parameter int WIDTH = demux_dispatch_pkg::ENTRY_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         full,
  output logic                         empty
);
  import demux_dispatch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [FW-1:0]    fill_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   fill_reg <= fill_reg + FW'(1);
        2'b01:   fill_reg <= fill_reg - FW'(1);
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign fill  = fill_reg;
  assign full  = (fill_reg == FW'(DEPTH));
  assign empty = (fill_reg == '0);

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Buffers (dest, data) requests and issues them in order to a demux with a
// one-hot lane strobe. Optional drop counter: define DEMUX_DISPATCH_ERR_CNT_EN.
module demux_dispatch_ctrl #(
  parameter int NUM_OUTPUT = demux_dispatch_pkg::NUM_OUTPUT,
  parameter int SEL_WIDTH  = demux_dispatch_pkg::SEL_WIDTH,
  parameter int DATA_WIDTH = demux_dispatch_pkg::DATA_WIDTH,
  parameter int DEPTH      = demux_dispatch_pkg::DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEL_WIDTH-1:0]         in_dest,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [NUM_OUTPUT-1:0]        dst_ready,
  output logic [SEL_WIDTH-1:0]         sel,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [NUM_OUTPUT-1:0]        lane_strobe,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         err_sticky,
`ifdef DEMUX_DISPATCH_ERR_CNT_EN
  output logic [7:0]                   err_cnt,
`endif
  input  logic                         err_clr
);
  import demux_dispatch_pkg::*;

  localparam int EW = SEL_WIDTH + DATA_WIDTH;

  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EW-1:0]         head;
  logic [SEL_WIDTH-1:0]  head_dest;
  logic [DATA_WIDTH-1:0] head_data;
  logic [NUM_OUTPUT-1:0] head_onehot;
  head_act_e             act;

  // No full-bypass: a same-cycle pop never opens the input
  assign in_ready = !fifo_full && !flush;
  assign push     = in_valid && in_ready;

  sync_fifo_param #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({in_dest, in_data}),
    .rdata (head),
    .fill  (fill),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_dest, head_data} = head;

  generate
    for (genvar gi = 0; gi < NUM_OUTPUT; gi++) begin : g_onehot
      assign head_onehot[gi] = (head_dest == SEL_WIDTH'(gi));
    end
  endgenerate

  always_comb begin
    act = ACT_IDLE;
    if (!flush && !fifo_empty) begin
      if (32'(head_dest) >= NUM_OUTPUT)       act = ACT_DROP;
      else if (|(head_onehot & dst_ready))    act = ACT_ISSUE;
      else                                    act = ACT_STALL;
    end
  end

  assign pop = (act == ACT_ISSUE) || (act == ACT_DROP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel         <= '0;
      data_out    <= '0;
      lane_strobe <= '0;
    end else begin
      lane_strobe <= '0;
      if (act == ACT_ISSUE) begin
        sel         <= head_dest;
        data_out    <= head_data;
        lane_strobe <= head_onehot;
      end
    end
  end

  // A drop in the same cycle as err_clr leaves the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_sticky <= 1'b0;
    else if (act == ACT_DROP)  err_sticky <= 1'b1;
    else if (err_clr)          err_sticky <= 1'b0;
  end

`ifdef DEMUX_DISPATCH_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (act == ACT_DROP) begin
      if (err_clr)                err_cnt <= 8'd1;
      else if (err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
    end else if (err_clr) begin
      err_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_demux_dispatch_ctrl;
  import demux_dispatch_pkg::*;

  localparam int N  = 15;
  localparam int SW = 4;
  localparam int DW = 4;
  localparam int D  = 4;
  localparam int FW = FILL_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_dest = '0;
  logic [DW-1:0] in_data = '0;
  logic [N-1:0]  dst_ready = '1;
  logic [SW-1:0] sel;
  logic [DW-1:0] data_out;
  logic [N-1:0]  lane_strobe;
  logic [FW-1:0] fill;
  logic          err_sticky;
  logic          err_clr = 1'b0;
`ifdef DEMUX_DISPATCH_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending requests plus last issued word
  int q_dest[$];
  int q_data[$];
  int m_sel, m_data, m_lane, m_err, m_cnt;

  demux_dispatch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dest     (in_dest),
    .in_data     (in_data),
    .dst_ready   (dst_ready),
    .sel         (sel),
    .data_out    (data_out),
    .lane_strobe (lane_strobe),
    .fill        (fill),
    .err_sticky  (err_sticky),
`ifdef DEMUX_DISPATCH_ERR_CNT_EN
    .err_cnt     (err_cnt),
`endif
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    q_dest.delete();
    q_data.delete();
    m_sel = 0; m_data = 0; m_lane = -1; m_err = 0; m_cnt = 0;
  endfunction

  function automatic logic [N-1:0] exp_strobe();
    logic [N-1:0] e;
    e = '0;
    if (m_lane >= 0) e[m_lane] = 1'b1;
    return e;
  endfunction

  // Advance the model by one clock using the current inputs, then clock the DUT
  task automatic step();
    bit acc, drop;
    #1;
    acc    = in_valid && (q_dest.size() < D) && !flush;
    drop   = 0;
    m_lane = -1;
    if (flush) begin
      q_dest.delete();
      q_data.delete();
    end else if (q_dest.size() > 0) begin
      if (q_dest[0] >= N) begin
        drop = 1;
        void'(q_dest.pop_front());
        void'(q_data.pop_front());
      end else if (dst_ready[q_dest[0]]) begin
        m_sel  = q_dest[0];
        m_data = q_data[0];
        m_lane = q_dest[0];
        void'(q_dest.pop_front());
        void'(q_data.pop_front());
      end
    end
    if (drop) begin
      m_err = 1;
      m_cnt = err_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (err_clr) begin
      m_err = 0;
      m_cnt = 0;
    end
    if (acc) begin
      q_dest.push_back(int'(in_dest));
      q_data.push_back(int'(in_data));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    flush    = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || fill !== '0 || sel !== '0 || data_out !== '0 ||
        lane_strobe !== '0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b fill=%0d sel=%0d data=%0h strobe=%h err=%b required 1/0/0/0/0/0",
               in_ready, fill, sel, data_out, lane_strobe, err_sticky);
    end
    $display("reset released: fill=%0d in_ready=%b", fill, in_ready);
  endtask

  task automatic test_sweep();
    logic [N-1:0] e;
    dst_ready = '1;
    for (int k = 0; k <= 15; k++) begin
      if (k < 15) begin
        in_valid = 1'b1;
        in_dest  = SW'(k);
        in_data  = 4'hA;
      end else begin
        in_valid = 1'b0;
      end
      step();
      e = '0;
      if (k >= 1) e[k-1] = 1'b1;
      checks++;
      if (lane_strobe !== e || (k >= 1 && (sel !== SW'(k-1) || data_out !== 4'hA))) begin
        errors++;
        $display("FAIL sweep[%0d]: strobe=%h sel=%0d data=%0h required strobe=%h sel=%0d data=a",
                 k, lane_strobe, sel, data_out, e, k - 1);
      end
      $display("sweep cycle %0d: strobe=%h sel=%0d data=%0h", k, lane_strobe, sel, data_out);
    end
  endtask

  task automatic test_backpressure();
    dst_ready    = '1;
    dst_ready[3] = 1'b0;
    in_valid = 1'b1; in_dest = 4'd3; in_data = 4'h1; step();
    in_valid = 1'b1; in_dest = 4'd5; in_data = 4'h2; step();
    in_valid = 1'b0;
    step();
    step();
    checks++;
    if (lane_strobe !== '0 || fill !== FW'(2)) begin
      errors++;
      $display("FAIL backpressure_hold: strobe=%h fill=%0d required strobe=0 fill=2", lane_strobe, fill);
    end
    dst_ready[3] = 1'b1;
    step();
    checks++;
    if (lane_strobe !== 15'h0008 || sel !== 4'd3 || data_out !== 4'h1) begin
      errors++;
      $display("FAIL backpressure_lane3: strobe=%h sel=%0d data=%0h required 0008/3/1", lane_strobe, sel, data_out);
    end
    step();
    checks++;
    if (lane_strobe !== 15'h0020 || sel !== 4'd5 || data_out !== 4'h2) begin
      errors++;
      $display("FAIL backpressure_lane5: strobe=%h sel=%0d data=%0h required 0020/5/2", lane_strobe, sel, data_out);
    end
    $display("backpressure released: lanes 3 then 5 issued, fill=%0d", fill);
  endtask

  task automatic test_full();
    dst_ready = '0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_dest  = SW'($urandom_range(0, N - 1));
      in_data  = DW'($urandom);
      #1;
      checks++;
      if (in_ready !== (i < 4)) begin
        errors++;
        $display("FAIL full_ready[%0d]: in_ready=%b required %b", i, in_ready, (i < 4));
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (fill !== FW'(4) || lane_strobe !== '0) begin
      errors++;
      $display("FAIL full_fill: fill=%0d strobe=%h required fill=4 strobe=0", fill, lane_strobe);
    end
    dst_ready = '1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (lane_strobe !== exp_strobe() || sel !== SW'(m_sel) || data_out !== DW'(m_data)) begin
        errors++;
        $display("FAIL full_drain[%0d]: strobe=%h sel=%0d data=%0h required %h/%0d/%0h",
                 i, lane_strobe, sel, data_out, exp_strobe(), m_sel, m_data);
      end
      $display("drain %0d: strobe=%h sel=%0d data=%0h", i, lane_strobe, sel, data_out);
    end
  endtask

  task automatic test_out_of_range();
    logic [SW-1:0] held_sel;
    held_sel = sel;
    dst_ready = '1;
    in_valid = 1'b1; in_dest = 4'd15; in_data = 4'h7; step();
    in_valid = 1'b0;
    step();
    checks++;
    if (lane_strobe !== '0 || err_sticky !== 1'b1 || sel !== held_sel || fill !== '0) begin
      errors++;
      $display("FAIL oor_drop: strobe=%h err=%b sel=%0d fill=%0d required 0/1/%0d/0",
               lane_strobe, err_sticky, sel, fill, held_sel);
    end
`ifdef DEMUX_DISPATCH_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL oor_cnt: err_cnt=%0d required 1", err_cnt);
    end
`endif
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL oor_clear: err=%b required 0", err_sticky);
    end
`ifdef DEMUX_DISPATCH_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL oor_cnt_clear: err_cnt=%0d required 0", err_cnt);
    end
`endif
    // Drop coincides with err_clr: set must win
    in_valid = 1'b1; in_dest = 4'd15; in_data = 4'h3; step();
    in_valid = 1'b0; err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL oor_set_wins: err=%b required 1", err_sticky);
    end
`ifdef DEMUX_DISPATCH_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL oor_cnt_set_wins: err_cnt=%0d required 1", err_cnt);
    end
`endif
    err_clr = 1'b1; step(); err_clr = 1'b0;
    $display("out-of-range drop: err_sticky=%b after clear", err_sticky);
  endtask

  task automatic test_flush();
    dst_ready = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_dest = SW'(i + 2); in_data = DW'(i + 9); step();
    end
    in_valid = 1'b0;
    checks++;
    if (fill !== FW'(3)) begin
      errors++;
      $display("FAIL flush_prefill: fill=%0d required 3", fill);
    end
    flush = 1'b1; in_valid = 1'b1; dst_ready = '1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
    end
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (fill !== '0 || lane_strobe !== '0) begin
      errors++;
      $display("FAIL flush_clear: fill=%0d strobe=%h required 0/0", fill, lane_strobe);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (lane_strobe !== '0 || fill !== '0) begin
        errors++;
        $display("FAIL flush_after[%0d]: strobe=%h fill=%0d required 0/0", i, lane_strobe, fill);
      end
    end
    $display("flush: fill=%0d", fill);
  endtask

  task automatic test_reset_midstream();
    dst_ready = '1;
    in_valid = 1'b1; in_dest = 4'd9; in_data = 4'hC; step();
    in_valid = 1'b0; step();
    dst_ready = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_dest = SW'(i + 1); in_data = DW'(i + 4); step();
    end
    in_valid = 1'b0;
    in_dest = 4'd15; in_data = 4'h5; in_valid = 1'b1; step(); in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (fill !== '0 || sel !== '0 || data_out !== '0 || lane_strobe !== '0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: fill=%0d sel=%0d data=%0h strobe=%h err=%b required all 0",
               fill, sel, data_out, lane_strobe, err_sticky);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dst_ready = '1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (lane_strobe !== '0 || fill !== '0) begin
        errors++;
        $display("FAIL reset_after[%0d]: strobe=%h fill=%0d required 0/0", i, lane_strobe, fill);
      end
    end
    $display("midstream reset: fill=%0d sel=%0d", fill, sel);
  endtask

  task automatic test_random();
    bit exp_ready;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_dest   = SW'($urandom_range(0, 15));
      in_data   = DW'($urandom);
      dst_ready = N'($urandom | $urandom);
      flush     = ($urandom_range(0, 19) == 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      #1;
      exp_ready = (q_dest.size() < D) && !flush;
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_ready[%0d]: in_ready=%b required %b", c, in_ready, exp_ready);
      end
      step();
      checks++;
      if (lane_strobe !== exp_strobe() || sel !== SW'(m_sel) || data_out !== DW'(m_data) ||
          fill !== FW'(q_dest.size()) || err_sticky !== m_err[0]) begin
        errors++;
        $display("FAIL rand_out[%0d]: strobe=%h sel=%0d data=%0h fill=%0d err=%b required %h/%0d/%0h/%0d/%0d",
                 c, lane_strobe, sel, data_out, fill, err_sticky,
                 exp_strobe(), m_sel, m_data, q_dest.size(), m_err);
      end
`ifdef DEMUX_DISPATCH_ERR_CNT_EN
      checks++;
      if (err_cnt !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: err_cnt=%0d required %0d", c, err_cnt, m_cnt);
      end
`endif
      if (m_lane >= 0)
        $display("rand cycle %0d: issue lane %0d data %0h fill %0d", c, m_lane, m_data, q_dest.size());
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_backpressure();
    test_full();
    test_out_of_range();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
